// File: rtl/downsampler.sv
// downsampler: 2x2 box-average decimator feeding a downstream FIFO write port.
//
// Ports:
//   clock              system clock, all logic on the rising edge
//   reset              synchronous active-high reset
//   valid              data/sof carry a pixel this cycle (no backpressure)
//   data[7:0]          input luma pixel
//   sof                start of frame, qualified by valid; forces pixel (0,0)
//   fifo_full          downstream FIFO cannot accept a write
//   dataout[7:0]       averaged output pixel, held between writes
//   fifo_write         one-cycle write strobe for dataout
//   overflow           sticky: an output pixel was dropped due to fifo_full
//   current_rowcount   input row of the next expected pixel
//   current_colcount   input column of the next expected pixel
module downsampler #(
  parameter int IN_COLS = 840,
  parameter int IN_ROWS = 480,
  parameter int CNT_W   = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid,
  input  logic [7:0]       data,
  input  logic             sof,
  input  logic             fifo_full,
  output logic [7:0]       dataout,
  output logic             fifo_write,
  output logic             overflow,
  output logic [CNT_W-1:0] current_rowcount,
  output logic [CNT_W-1:0] current_colcount
);

  localparam int HALF = IN_COLS / 2;
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IN_COLS - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IN_ROWS - 1);

  logic [CNT_W-1:0] col_eff;
  logic [CNT_W-1:0] row_eff;
  logic [CNT_W-1:0] col_next;
  logic [CNT_W-1:0] row_next;
  logic [7:0]       pair_q;
  logic [8:0]       linebuf [HALF];
  logic [AW-1:0]    k;
  logic [8:0]       pair_sum;
  logic [9:0]       total;
  logic [7:0]       avg;
  logic             pair_done;
  logic             block_done;

  always_comb begin
    // sof overrides the counters: the pixel is treated as (0,0), which also
    // discards any partial pair because column 0 recaptures the pair register.
    col_eff    = sof ? '0 : current_colcount;
    row_eff    = sof ? '0 : current_rowcount;
    k          = col_eff[AW:1];
    pair_sum   = {1'b0, pair_q} + {1'b0, data};
    total      = {1'b0, linebuf[k]} + {1'b0, pair_sum};
    // Round half up; the maximum 1022 >> 2 = 255 always fits in 8 bits.
    avg        = 8'((total + 10'd2) >> 2);
    pair_done  = valid & col_eff[0];
    block_done = pair_done & row_eff[0];

    col_next = col_eff + 1'b1;
    row_next = row_eff;
    if (col_eff == COL_LAST) begin
      col_next = '0;
      row_next = (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
    end
  end

  // Line buffer holds even-row pair sums; it is written on even rows and read
  // on odd rows, so one entry is never read and written in the same cycle.
  always_ff @(posedge clock) begin
    if (!reset && pair_done && !row_eff[0]) begin
      linebuf[k] <= pair_sum;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dataout          <= '0;
      fifo_write       <= 1'b0;
      overflow         <= 1'b0;
      current_rowcount <= '0;
      current_colcount <= '0;
      pair_q           <= '0;
    end else begin
      fifo_write <= 1'b0;
      if (valid) begin
        current_colcount <= col_next;
        current_rowcount <= row_next;
        if (!col_eff[0]) begin
          pair_q <= data;
        end
        if (block_done) begin
          if (fifo_full) begin
            overflow <= 1'b1;
          end else begin
            fifo_write <= 1'b1;
            dataout    <= avg;
          end
        end
      end
    end
  end

endmodule
